// File: rtl/hs_upload_server_if.sv
// hps_io ioctl upload channel: request side driven by hps_io, data/throttle by the core.
interface hs_upload_server_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ioctl_upload_req;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait, ioctl_upload_req
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait, ioctl_upload_req
    );
endinterface

// File: rtl/hs_upload_server.sv
// Serves HPS ioctl uploads of the hiscore/NVRAM region: pauses the CPU, fetches
// each requested byte from RAM while stalling hps_io, and raises autosave requests.
module hs_upload_server #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DEPTH      = 4096,
    parameter logic [7:0]  UPLOAD_IDX = 8'd4,
    parameter int unsigned RAM_LAT    = 1,
    parameter logic [23:0] HOLDOFF    = 24'd2400000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    hs_upload_server_if.slave hps,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_data,
    output logic              pause_req,
    input  logic              pause_ack,
    input  logic              dirty,
    input  logic              autosave,
    output logic              busy
);

    typedef enum logic [2:0] {StIdle, StPausing, StReady, StFetch, StPresent} state_e;

    state_e      state_q;
    logic        active_q;
    logic        pend_q;
    logic        served_q;
    logic [24:0] addr_q;
    logic [1:0]  lat_q;
    logic        flag_q;
    logic        requested_q;
    logic [23:0] hold_q;

    logic        active;
    logic        upload_end;
    logic        rd_any;
    logic [24:0] rd_addr;
    logic        rd_ok;
    logic        issue;

    assign active     = hps.ioctl_upload && (hps.ioctl_index == UPLOAD_IDX);
    assign upload_end = (state_q != StIdle) && !active;
    // A read latched before the pause completed takes precedence over the live request lines.
    assign rd_any     = pend_q || hps.ioctl_rd;
    assign rd_addr    = pend_q ? addr_q : hps.ioctl_addr;
    // Full 25-bit compare so addresses with upper bits set are out of range.
    assign rd_ok      = 32'(rd_addr) < DEPTH;
    // PRESENT accepts a back-to-back read so hps_io is never dropped on the floor.
    assign issue      = rd_any && ((state_q == StPausing && pause_ack) ||
                                   state_q == StReady || state_q == StPresent);

    // Upload FSM with registered ioctl, RAM and pause outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            active_q       <= 1'b0;
            pend_q         <= 1'b0;
            served_q       <= 1'b0;
            addr_q         <= '0;
            lat_q          <= '0;
            hps.ioctl_din  <= '0;
            hps.ioctl_wait <= 1'b0;
            ram_addr       <= '0;
            ram_rd         <= 1'b0;
            pause_req      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            active_q <= active;
            ram_rd   <= 1'b0;
            if (upload_end) begin
                // Abort whatever is in flight; the fetched byte (if any) is discarded.
                state_q        <= StIdle;
                pend_q         <= 1'b0;
                pause_req      <= 1'b0;
                hps.ioctl_wait <= 1'b0;
                busy           <= 1'b0;
            end else if (issue) begin
                pend_q <= 1'b0;
                addr_q <= rd_addr;
                if (rd_ok) begin
                    state_q        <= StFetch;
                    ram_addr       <= rd_addr[ADDR_W-1:0];
                    ram_rd         <= 1'b1;
                    lat_q          <= '0;
                    hps.ioctl_wait <= 1'b1;
                end else begin
                    // Out of range: return zero immediately without touching RAM.
                    state_q        <= StReady;
                    hps.ioctl_din  <= 8'h00;
                    hps.ioctl_wait <= 1'b0;
                    served_q       <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (active && !active_q) begin
                            state_q   <= StPausing;
                            pause_req <= 1'b1;
                            busy      <= 1'b1;
                            served_q  <= 1'b0;
                            if (hps.ioctl_rd) begin
                                pend_q         <= 1'b1;
                                addr_q         <= hps.ioctl_addr;
                                hps.ioctl_wait <= 1'b1;
                            end
                        end
                    end
                    StPausing: begin
                        if (pause_ack) begin
                            state_q <= StReady;
                        end else if (hps.ioctl_rd && !pend_q) begin
                            pend_q         <= 1'b1;
                            addr_q         <= hps.ioctl_addr;
                            hps.ioctl_wait <= 1'b1;
                        end
                    end
                    StReady: begin
                        state_q <= StReady;
                    end
                    StFetch: begin
                        if (lat_q == 2'(RAM_LAT)) begin
                            hps.ioctl_din  <= ram_data;
                            hps.ioctl_wait <= 1'b0;
                            served_q       <= 1'b1;
                            state_q        <= StPresent;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end
                    StPresent: begin
                        state_q <= StReady;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Dirty tracking and holdoff timer; one upload request per dirty episode.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            flag_q               <= 1'b0;
            requested_q          <= 1'b0;
            hold_q               <= '0;
            hps.ioctl_upload_req <= 1'b0;
        end else begin
            hps.ioctl_upload_req <= 1'b0;
            if (upload_end && served_q) begin
                flag_q      <= 1'b0;
                requested_q <= 1'b0;
            end else if (dirty) begin
                // Loaded one short so the request lands HOLDOFF cycles after the strobe.
                flag_q <= 1'b1;
                hold_q <= HOLDOFF - 24'd1;
            end else if (state_q == StIdle && flag_q) begin
                if (hold_q != 24'd0) begin
                    hold_q <= hold_q - 24'd1;
                end
                if (autosave && !requested_q && hold_q <= 24'd1) begin
                    hps.ioctl_upload_req <= 1'b1;
                    requested_q          <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/hs_upload_server.md
Name: hs_upload_server

Overview:
- Serves HPS-initiated ioctl uploads (core → HPS) of the hiscore/NVRAM region for the save-file path.
- Complements the download path: reads a byte-wide RAM port, presents each byte on ioctl_din, and throttles hps_io with ioctl_wait.
- Pauses the game CPU for the whole upload so the saved data is coherent.
- Issues ioctl_upload_req after game-side writes when autosave is enabled.

Parameters:
- ADDR_W, 12, RAM address width (addressable region 2^ADDR_W bytes)
- DEPTH, 4096, valid bytes in region; must be ≤ 2^ADDR_W
- UPLOAD_IDX, 8'd4, ioctl_index value this block answers
- RAM_LAT, 1, RAM read latency in cycles (1..3)
- HOLDOFF, 24'd2400000, idle cycles after the last dirty strobe before requesting upload (100 ms at 24 MHz)

Ports:
- clk_sys  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous active-low reset
- ioctl_upload  in  1  hps_io upload active level
- ioctl_index  in  8  current transfer index
- ioctl_rd  in  1  one-cycle byte read request from hps_io
- ioctl_addr  in  25  byte address of the request
- ioctl_din  out  8  byte returned to hps_io
- ioctl_wait  out  1  high = ioctl_din not yet valid; hps_io stalls
- ioctl_upload_req  out  1  one-cycle request for HPS to start an upload
- ram_addr  out  ADDR_W  RAM read address
- ram_rd  out  1  RAM read strobe, one cycle
- ram_data  in  8  RAM read data, valid RAM_LAT cycles after ram_rd
- pause_req  out  1  request CPU pause
- pause_ack  in  1  CPU is paused
- dirty  in  1  one-cycle pulse when game writes hiscore RAM
- autosave  in  1  enable automatic upload requests
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n=0), all outputs 0:
  - ioctl_din=0, ioctl_wait=0, ioctl_upload_req=0, ram_rd=0, ram_addr=0, pause_req=0, busy=0.
  - FSM returns to IDLE; holdoff counter and dirty flag are cleared.
- active = ioctl_upload && ioctl_index==UPLOAD_IDX.
- FSM states: IDLE, PAUSING, READY, FETCH, PRESENT.
- IDLE:
  - Rising edge of active → PAUSING; pause_req=1 from the next cycle.
  - An ioctl_rd seen in IDLE while active is latched and served after the pause.
- PAUSING:
  - Hold pause_req=1.
  - If a read is pending, ioctl_wait=1.
  - On pause_ack=1 → READY, or → FETCH if a read is pending.
- READY: on ioctl_rd (while active), latch ioctl_addr and raise ioctl_wait the next cycle.
  - If ioctl_addr < DEPTH → FETCH.
  - Otherwise ioctl_din=8'h00, ioctl_wait stays 0 and the state stays READY. Zero-latency return, no RAM access.
- FETCH:
  - Drive ram_addr = latched addr[ADDR_W-1:0] and ram_rd=1 for one cycle.
  - Count RAM_LAT cycles, then capture ram_data into ioctl_din → PRESENT.
- PRESENT: drop ioctl_wait to 0 for this cycle; ioctl_din holds until the next capture → READY.
- Read latency: a valid-address ioctl_rd takes RAM_LAT+2 cycles from rd to ioctl_wait falling.
- ioctl_rd arriving while ioctl_wait=1 is ignored; hps_io must not issue it.
- Upload end: active falls in any non-IDLE state →
  - Abort any fetch in flight, then IDLE next cycle.
  - pause_req=0, ioctl_wait=0.
  - Clear the dirty flag only if at least one byte was served.
- Autosave, while in IDLE:
  - dirty sets the dirty flag and reloads the holdoff counter to HOLDOFF.
  - The counter decrements each cycle while the flag is set.
  - At 0 with autosave=1, pulse ioctl_upload_req for 1 cycle, then hold the flag without re-requesting until an upload completes.
  - autosave=0: no request is ever issued; the flag is kept.
- dirty during a non-IDLE state: sets the flag for a later request and does not affect the current upload.
- Simultaneous dirty and upload start: the upload wins; the flag is set and cleared at upload end if bytes were served.
- Latched address width: use ioctl_addr[24:0] for the DEPTH compare, so upper-bit addresses are out of range.

Test Plan:
- Upload start, index=4, pause_ack 3 cycles later → pause_req=1 the cycle after active; ioctl_rd addr 0 with RAM[0]=8'hA5, RAM_LAT=1 → ram_rd=1 on addr 0, ioctl_wait high 2 cycles then falls with ioctl_din=8'hA5.
- Sequential reads addr 0..4095 with RAM[i]=i[7:0] → every byte matches; pause_req stays 1 throughout; ioctl_upload falls → pause_req=0 and busy=0 the next cycle.
- ioctl_rd addr 4096 (DEPTH=4096) → ioctl_din=8'h00, ioctl_wait never high, ram_rd stays 0.
- Upload with index=3 → no pause_req, no ram_rd, ioctl_wait stays 0.
- autosave=1, dirty pulse, HOLDOFF=100 → ioctl_upload_req single pulse exactly 100 cycles later; second dirty at cycle 50 → pulse moves to 100 cycles after the second dirty; autosave=0 → no pulse.
- reset_n low during FETCH → all outputs 0 immediately (async); after release, next upload starts cleanly from IDLE.
